// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush/redirect sequencer.
// Holds the FSM and cause encodings and the packed per-register control vector.
package pipeline_ctrl_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_REDIR_WAIT = 2'd1,
    ST_TRAP_WAIT  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    C_NONE     = 3'd0,
    C_TRAP     = 3'd1,
    C_TRAP_MEM = 3'd2,
    C_MEM      = 3'd3,
    C_EX       = 3'd4,
    C_BRANCH   = 3'd5,
    C_LOAD_USE = 3'd6,
    C_IF       = 3'd7
  } cause_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic stall_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
  } pipe_ctl_t;

  localparam int PIPE_CTL_W = $bits(pipe_ctl_t);

  // A bubble overrides a hold on the same register.
  function automatic pipe_ctl_t flush_wins(input pipe_ctl_t c);
    pipe_ctl_t r;
    r = c;
    r.stall_if_id  = c.stall_if_id  & ~c.flush_if_id;
    r.stall_id_ex  = c.stall_id_ex  & ~c.flush_id_ex;
    r.stall_ex_mem = c.stall_ex_mem & ~c.flush_ex_mem;
    r.stall_mem_wb = c.stall_mem_wb & ~c.flush_mem_wb;
    return r;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_prio.sv
// Combinational priority encoder: hazard causes -> winning cause and stall/flush vector.
// Zero latency; order is trap > mem_busy > ex_busy > branch > load_use > if_busy.
module pipeline_ctrl_prio
  import pipeline_ctrl_pkg::*;
(
  input  logic                  trap_valid_i,
  input  logic                  mem_busy_i,
  input  logic                  ex_busy_i,
  input  logic                  branch_valid_i,
  input  logic                  load_use_i,
  input  logic                  if_busy_i,
  output logic [2:0]            cause_o,
  output logic [PIPE_CTL_W-1:0] ctl_o
);

  pipe_ctl_t ctl;
  cause_e    cause;

  always_comb begin
    ctl   = '0;
    cause = C_NONE;
    if (trap_valid_i) begin
      ctl.flush_if_id  = 1'b1;
      ctl.flush_id_ex  = 1'b1;
      ctl.flush_ex_mem = 1'b1;
      if (mem_busy_i) begin
        // Trap waits for the older LSU access; fetch is frozen meanwhile.
        cause        = C_TRAP_MEM;
        ctl.stall_pc = 1'b1;
      end else begin
        cause = C_TRAP;
      end
    end else if (mem_busy_i) begin
      cause            = C_MEM;
      ctl.stall_pc     = 1'b1;
      ctl.stall_if_id  = 1'b1;
      ctl.stall_id_ex  = 1'b1;
      ctl.stall_ex_mem = 1'b1;
      ctl.flush_mem_wb = 1'b1;
    end else if (ex_busy_i) begin
      cause            = C_EX;
      ctl.stall_pc     = 1'b1;
      ctl.stall_if_id  = 1'b1;
      ctl.stall_id_ex  = 1'b1;
      ctl.flush_ex_mem = 1'b1;
    end else if (branch_valid_i) begin
      cause           = C_BRANCH;
      ctl.flush_if_id = 1'b1;
      ctl.flush_id_ex = 1'b1;
    end else if (load_use_i) begin
      cause           = C_LOAD_USE;
      ctl.stall_pc    = 1'b1;
      ctl.stall_if_id = 1'b1;
      ctl.flush_id_ex = 1'b1;
    end else if (if_busy_i) begin
      cause           = C_IF;
      ctl.stall_pc    = 1'b1;
      ctl.flush_if_id = 1'b1;
    end
  end

  assign cause_o = cause;
  assign ctl_o   = ctl;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage core; outputs are combinational, same cycle.
// Redirects blocked by an in-flight fetch or LSU access are parked in pend_pc until it drains.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_i,
  input  logic             if_busy_i,
  input  logic             ex_busy_i,
  input  logic             mem_busy_i,
  input  logic             branch_valid_i,
  input  logic [XLEN-1:0]  branch_pc_i,
  input  logic             trap_valid_i,
  input  logic [XLEN-1:0]  trap_pc_i,
  output logic             stall_pc_o,
  output logic             stall_if_id_o,
  output logic             stall_id_ex_o,
  output logic             stall_ex_mem_o,
  output logic             stall_mem_wb_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             flush_ex_mem_o,
  output logic             flush_mem_wb_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  state_e                  state_q, state_d;
  logic [XLEN-1:0]         pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic [2:0]              prio_cause;
  logic [PIPE_CTL_W-1:0]   prio_ctl;
  pipe_ctl_t               ctl, ctl_out;
  logic                    redir_vld;
  logic [XLEN-1:0]         redir_pc, tw_tgt;

  pipeline_ctrl_prio u_prio (
    .trap_valid_i   (trap_valid_i),
    .mem_busy_i     (mem_busy_i),
    .ex_busy_i      (ex_busy_i),
    .branch_valid_i (branch_valid_i),
    .load_use_i     (load_use_i),
    .if_busy_i      (if_busy_i),
    .cause_o        (prio_cause),
    .ctl_o          (prio_ctl)
  );

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    ctl       = '0;
    redir_vld = 1'b0;
    redir_pc  = '0;
    tw_tgt    = trap_valid_i ? trap_pc_i : pend_pc_q;
    case (state_q)
      ST_RUN: begin
        ctl = pipe_ctl_t'(prio_ctl);
        case (cause_e'(prio_cause))
          C_TRAP: begin
            if (!if_busy_i) begin
              redir_vld = 1'b1;
              redir_pc  = trap_pc_i;
            end else begin
              pend_pc_d = trap_pc_i;
              state_d   = ST_REDIR_WAIT;
            end
          end
          C_TRAP_MEM: begin
            pend_pc_d = trap_pc_i;
            state_d   = ST_TRAP_WAIT;
          end
          C_BRANCH: begin
            if (!if_busy_i) begin
              redir_vld = 1'b1;
              redir_pc  = branch_pc_i;
            end else begin
              pend_pc_d = branch_pc_i;
              state_d   = ST_REDIR_WAIT;
            end
          end
          default: ;
        endcase
      end
      ST_REDIR_WAIT: begin
        // The PC hold is overridden by redirect at the PC register itself.
        ctl.stall_pc    = 1'b1;
        ctl.flush_if_id = 1'b1;
        if (trap_valid_i) begin
          ctl.flush_id_ex  = 1'b1;
          ctl.flush_ex_mem = 1'b1;
          pend_pc_d        = trap_pc_i;
          if (mem_busy_i) begin
            state_d = ST_TRAP_WAIT;
          end else if (!if_busy_i) begin
            redir_vld = 1'b1;
            redir_pc  = trap_pc_i;
            state_d   = ST_RUN;
          end
        end else if (!if_busy_i) begin
          redir_vld = 1'b1;
          redir_pc  = pend_pc_q;
          state_d   = ST_RUN;
        end
      end
      ST_TRAP_WAIT: begin
        ctl.stall_pc     = 1'b1;
        ctl.flush_if_id  = 1'b1;
        ctl.flush_id_ex  = 1'b1;
        ctl.flush_ex_mem = 1'b1;
        pend_pc_d        = tw_tgt;
        if (!mem_busy_i) begin
          ctl.flush_mem_wb = 1'b1;
          if (!if_busy_i) begin
            redir_vld = 1'b1;
            redir_pc  = tw_tgt;
            state_d   = ST_RUN;
          end else begin
            state_d = ST_REDIR_WAIT;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign ctl_out = rst ? flush_wins(ctl) : '0;

  assign stall_pc_o       = ctl_out.stall_pc;
  assign stall_if_id_o    = ctl_out.stall_if_id;
  assign stall_id_ex_o    = ctl_out.stall_id_ex;
  assign stall_ex_mem_o   = ctl_out.stall_ex_mem;
  assign stall_mem_wb_o   = ctl_out.stall_mem_wb;
  assign flush_if_id_o    = ctl_out.flush_if_id;
  assign flush_id_ex_o    = ctl_out.flush_id_ex;
  assign flush_ex_mem_o   = ctl_out.flush_ex_mem;
  assign flush_mem_wb_o   = ctl_out.flush_mem_wb;
  assign redirect_valid_o = rst & redir_vld;
  assign redirect_pc_o    = redirect_valid_o ? redir_pc : '0;

  assign stall_cnt_d = stall_pc_o ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      pend_pc_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush/redirect sequencer for the 5-stage in-order core. Collects hazard and busy indications from IF, ID, EX and MEM. Collects redirect requests from EX (branch/jump) and from the commit point (trap/mret). Drives per-register stall and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus a single PC redirect. Holds redirects and traps that cannot complete immediately because a fetch or LSU transaction is in flight.

## Interface
- XLEN, default `XLEN: PC width.
- CNT_W, default 32: stall performance counter width.
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_use_i  in  1  ID needs a result of the load currently in EX.
- if_busy_i  in  1  fetch transaction outstanding; the IF output is not yet valid.
- ex_busy_i  in  1  multi-cycle mul/div is occupying EX.
- mem_busy_i  in  1  LSU transaction outstanding in MEM.
- branch_valid_i / branch_pc_i  in  1 / XLEN  taken branch or jump resolved in EX.
- trap_valid_i / trap_pc_i  in  1 / XLEN  trap or mret accepted at commit; target PC.
- stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o  out  1 each  hold the register.
- flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o  out  1 each  load a bubble (NOP, addr 0, trap bus 0).
- redirect_valid_o / redirect_pc_o  out  1 / XLEN  load the PC with redirect_pc_o this cycle.
- stall_cnt_o  out  CNT_W  count of cycles with stall_pc_o=1.

## Operation
- State machine states: RUN, REDIR_WAIT, TRAP_WAIT. Registers: state, pend_pc (XLEN), stall_cnt.
- In RUN, causes are evaluated in priority order: trap > mem_busy > ex_busy > branch > load_use > if_busy.
- RUN, trap_valid_i with mem_busy_i=0:
  - flush_if_id, flush_id_ex and flush_ex_mem are asserted.
  - If if_busy_i=0: redirect_valid_o=1 with trap_pc_i.
  - Otherwise: pend_pc ← trap_pc_i and the next state is REDIR_WAIT.
- RUN, trap_valid_i with mem_busy_i=1: pend_pc ← trap_pc_i and the next state is TRAP_WAIT.
- RUN, mem_busy_i: stall PC, IF/ID, ID/EX and EX/MEM; flush MEM/WB.
- RUN, ex_busy_i: stall PC, IF/ID and ID/EX; flush EX/MEM.
- RUN, branch_valid_i: flush IF/ID and ID/EX.
  - If if_busy_i=0: redirect with branch_pc_i.
  - Otherwise: pend_pc ← branch_pc_i and the next state is REDIR_WAIT.
- RUN, load_use_i: stall PC and IF/ID; flush ID/EX.
- RUN, if_busy_i only: stall PC; flush IF/ID.
- REDIR_WAIT:
  - Each cycle: stall_pc_o=1 and flush_if_id_o=1.
  - When if_busy_i=0: redirect_valid_o=1 with pend_pc, flush_if_id_o=1 to discard the stale fetched word, and the next state is RUN.
- TRAP_WAIT:
  - Each cycle: stall PC; flush IF/ID, ID/EX and EX/MEM.
  - When mem_busy_i=0: flush MEM/WB.
  - Then redirect with pend_pc if if_busy_i=0 (next state RUN); otherwise the next state is REDIR_WAIT.
- Simultaneous events:
  - Trap and branch in the same cycle: trap wins; the branch is dropped.
  - Branch in REDIR_WAIT or TRAP_WAIT: ignored, because it belongs to a flushed younger instruction.
  - Trap in REDIR_WAIT: overwrites pend_pc. If mem_busy_i=1 the next state is TRAP_WAIT; otherwise the trap is serviced as in RUN.
  - Trap in TRAP_WAIT: overwrites pend_pc.
- A register is never both stalled and flushed; flush wins.
- stall_cnt increments on every cycle with stall_pc_o=1 and wraps modulo 2^CNT_W.

## Timing
- redirect, stall and flush outputs are combinational from the inputs and the current state, and are valid in the same cycle.
- Branch or trap to redirect latency:
  - 0 cycles when fetch (and, for a trap, the LSU) is idle.
  - Otherwise 0 cycles after if_busy_i (and, for a trap, mem_busy_i) falls.
- While rst is low:
  - state=RUN, pend_pc=0, stall_cnt=0.
  - All stall, flush and redirect outputs are 0, and redirect_pc_o=0.
- Reset asserted mid-wait drops any pending redirect and trap.
- redirect_pc_o = pend_pc in the wait states and the live input PC in RUN. It is 0 whenever redirect_valid_o=0.

## Structure
- sysconfig.v receives:
  - the state encodings `PCTRL_RUN, `PCTRL_REDIR_WAIT and `PCTRL_TRAP_WAIT (2 bits);
  - `PCTRL_CNT_W.
- One sub-module, pipeline_ctrl_prio: purely combinational priority encoder mapping the causes to the stall/flush vector. The FSM, pend_pc and the counter live in pipeline_ctrl.
- State registers use their own async-reset always block; regTemplate is not used.

## Test plan
- Reset: rst=0 while load_use_i=1 → all outputs 0 and stall_cnt_o=0. After release, state is RUN.
- load_use_i for 1 cycle → stall_pc_o=stall_if_id_o=1 and flush_id_ex_o=1 for exactly 1 cycle; stall_cnt_o becomes 1.
- branch_valid_i, branch_pc_i=0x8000_0040, if_busy_i=1 for 3 cycles:
  - redirect_valid_o=0 for 3 cycles with flush_if_id_o=1;
  - on the cycle if_busy_i=0: redirect_valid_o=1 with pc 0x8000_0040;
  - then RUN.
- trap_valid_i, trap_pc_i=0x8000_0100, mem_busy_i=1 for 2 cycles → TRAP_WAIT with IF/ID, ID/EX and EX/MEM flushed. When mem drains: flush_mem_wb_o=1 and redirect to 0x8000_0100.
- Trap and branch in the same cycle (trap 0x100, branch 0x200) → redirect_pc_o=0x100 and flush_ex_mem_o=1.
- Trap during REDIR_WAIT (pending 0x200, trap 0x300, mem idle) → the eventual redirect is 0x300 and the old 0x200 never appears.
